// File: rtl/alu_pkg.sv
// Shared types for the ALU command path.
// Opcodes, parser states and error codes.
package alu_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA1;
  localparam logic [7:0] OP_MUL  = 8'hB2;
  localparam logic [7:0] OP_DIV  = 8'hC3;

  localparam int HDR_BYTES = 4;

  typedef enum logic [2:0] {
    S_HDR_OP,
    S_HDR_RSV,
    S_HDR_LLO,
    S_HDR_LHI,
    S_PAYLOAD,
    S_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OP   = 2'd1,
    ERR_LEN  = 2'd2,
    ERR_TMO  = 2'd3
  } err_e;

  function automatic logic is_legal_op(
    input logic [7:0] op
  );
    return (op == OP_ECHO) || (op == OP_ADD) ||
           (op == OP_MUL)  || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs payload bytes into 32-bit LE words.
// Single-entry output register with valid/ready.
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_vld,
  input  logic [7:0]  in_byte,
  input  logic [7:0]  in_user,
  input  logic        in_last,
  output logic [1:0]  k,
  output logic        out_free,
  output logic [31:0] m_axis_tdata,
  output logic [7:0]  m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
);

  logic [23:0] word_q;
  logic [1:0]  k_q;

  assign k        = k_q;
  assign out_free = !m_axis_tvalid || m_axis_tready;

  // Shift bytes in from the top; 4th byte loads the output word.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q        <= '0;
      k_q           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready)
        m_axis_tvalid <= 1'b0;
      if (clr) begin
        k_q <= '0;
      end else if (in_vld) begin
        k_q    <= k_q + 2'd1;
        word_q <= {in_byte, word_q[23:8]};
        if (k_q == 2'd3) begin
          m_axis_tdata  <= {in_byte, word_q};
          m_axis_tuser  <= in_user;
          m_axis_tlast  <= in_last;
          m_axis_tvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_cmd_parser.sv
// Frames UART bytes into ALU operand words.
// Header check, payload/drain and idle timeout.
module alu_cmd_parser
  import alu_pkg::*;
#(
  parameter int MAX_LEN_P     = 256,
  parameter int TIMEOUT_CYC_P = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic [7:0]  m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  localparam int TW = $clog2(TIMEOUT_CYC_P + 1);

  state_e        state_q, state_d;
  logic [7:0]    op_q, op_d;
  logic [7:0]    len_lo_q, len_lo_d;
  logic [15:0]   rem_q, rem_d;
  logic [TW-1:0] tmo_q, tmo_d;
  err_e          code_q, code_d;
  logic          err_q, err_d;

  logic [15:0]   len_w;
  logic          acc, op_ok, len_ok, tmo_hit;
  logic          out_free, wa_vld, wa_clr, wa_last;
  logic [1:0]    k;

  assign acc    = s_axis_tvalid && s_axis_tready;
  assign len_w  = {s_axis_tdata, len_lo_q};
  assign op_ok  = is_legal_op(op_q);
  assign len_ok = (len_w[1:0] == 2'b00) &&
                  (len_w >= 16'd8) &&
                  (len_w <= 16'(MAX_LEN_P));

  assign tmo_hit = (state_q != S_HDR_OP) && !acc &&
                   (tmo_q == TW'(TIMEOUT_CYC_P - 1));

  assign s_axis_tready =
    (state_q == S_PAYLOAD && k == 2'd3) ? out_free : 1'b1;

  assign wa_vld  = acc && (state_q == S_PAYLOAD);
  assign wa_last = (rem_q == 16'd1);
  assign wa_clr  = (state_q != S_PAYLOAD) || tmo_hit;

  word_assembler u_wa (
    .clk           (clk),
    .rst           (rst),
    .clr           (wa_clr),
    .in_vld        (wa_vld),
    .in_byte       (s_axis_tdata),
    .in_user       (op_q),
    .in_last       (wa_last),
    .k             (k),
    .out_free      (out_free),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  // Parser state, header fields, timeout and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_HDR_OP;
      op_q     <= '0;
      len_lo_q <= '0;
      rem_q    <= '0;
      tmo_q    <= '0;
      code_q   <= ERR_NONE;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      len_lo_q <= len_lo_d;
      rem_q    <= rem_d;
      tmo_q    <= tmo_d;
      code_q   <= code_d;
      err_q    <= err_d;
    end
  end

  // Next-state: header walk, length check, payload/drain count.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    len_lo_d = len_lo_q;
    rem_d    = rem_q;
    code_d   = code_q;
    err_d    = 1'b0;
    tmo_d    = (state_q == S_HDR_OP || acc) ?
               '0 : tmo_q + 1'b1;
    if (tmo_hit) begin
      state_d = S_HDR_OP;
      err_d   = 1'b1;
      code_d  = ERR_TMO;
      tmo_d   = '0;
    end else if (acc) begin
      unique case (state_q)
        S_HDR_OP: begin
          op_d    = s_axis_tdata;
          state_d = S_HDR_RSV;
        end
        S_HDR_RSV: state_d = S_HDR_LLO;
        S_HDR_LLO: begin
          len_lo_d = s_axis_tdata;
          state_d  = S_HDR_LHI;
        end
        S_HDR_LHI: begin
          unique case (1'b1)
            op_ok && len_ok: begin
              rem_d   = len_w - 16'(HDR_BYTES);
              state_d = S_PAYLOAD;
            end
            default: begin
              err_d  = 1'b1;
              code_d = op_ok ? ERR_LEN : ERR_OP;
              if (len_w > 16'(HDR_BYTES)) begin
                rem_d   = len_w - 16'(HDR_BYTES);
                state_d = S_DRAIN;
              end else begin
                state_d = S_HDR_OP;
              end
            end
          endcase
        end
        S_PAYLOAD, S_DRAIN: begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1)
            state_d = S_HDR_OP;
        end
        default: state_d = S_HDR_OP;
      endcase
    end
  end

  assign err_o      = err_q;
  assign err_code_o = code_q;

endmodule

// File: tb/tb_alu_cmd_parser.sv
// Directed bench for alu_cmd_parser.
// Vector table plus multi-cycle corner sequences.
module tb_alu_cmd_parser;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [7:0]  m_tuser;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic        err_o;
  logic [1:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;
  int nsent   = 0;

  logic [31:0] got_w[$];
  logic [7:0]  got_u[$];
  logic        got_l[$];
  logic [1:0]  got_e[$];

  always #5 clk = ~clk;

  alu_cmd_parser #(
    .MAX_LEN_P     (256),
    .TIMEOUT_CYC_P (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .err_o         (err_o),
    .err_code_o    (err_code)
  );

  // Capture output handshakes and error pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid && m_tready) begin
        got_w.push_back(m_tdata);
        got_u.push_back(m_tuser);
        got_l.push_back(m_tlast);
      end
      if (err_o)
        got_e.push_back(err_code);
    end
  end

  typedef struct {
    string        nm;
    int           nb;
    logic [127:0] bs;
    int           nw;
    logic [31:0]  w0;
    logic [31:0]  w1;
    logic [31:0]  w2;
    logic [7:0]   u;
    logic [2:0]   lm;
    int           ne;
    logic [1:0]   e0;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(
    input string nm, input int nb,
    input logic [127:0] bs, input int nw,
    input logic [31:0] w0, input logic [31:0] w1,
    input logic [31:0] w2, input logic [7:0] u,
    input logic [2:0] lm, input int ne,
    input logic [1:0] e0
  );
    vec_t v;
    v.nm = nm; v.nb = nb; v.bs = bs; v.nw = nw;
    v.w0 = w0; v.w1 = w1; v.w2 = w2; v.u = u;
    v.lm = lm; v.ne = ne; v.e0 = e0;
    vecs.push_back(v);
  endtask

  task automatic chk(
    input string nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, got, exp);
    end
  endtask

  task automatic clr_q();
    got_w.delete();
    got_u.delete();
    got_l.delete();
    got_e.delete();
  endtask

  task automatic send_one(input logic [7:0] b);
    int n;
    s_tdata  = b;
    s_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      n++;
      if (n > 500) begin
        $display("FAIL send_timeout: byte %h stuck", b);
        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail + 1);
        $fatal(1, "input stalled");
      end
    end
    @(posedge clk);
    #1;
    nsent++;
  endtask

  task automatic send_bs(
    input logic [127:0] bs, input int nb
  );
    for (int j = 0; j < nb; j++)
      send_one(bs[127 - 8*j -: 8]);
    s_tvalid = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] wsel(
    input vec_t v, input int j
  );
    return (j == 0) ? v.w0 : (j == 1) ? v.w1 : v.w2;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [31:0] ew;
    clr_q();
    send_bs(v.bs, v.nb);
    settle();
    chk({v.nm, " nwords"}, got_w.size(), v.nw);
    for (int j = 0; j < v.nw; j++) begin
      if (j < got_w.size()) begin
        ew = wsel(v, j);
        chk({v.nm, " data"}, got_w[j], ew);
        chk({v.nm, " user"}, 32'(got_u[j]), 32'(v.u));
        chk({v.nm, " last"}, 32'(got_l[j]),
            32'(v.lm[j]));
      end
    end
    chk({v.nm, " nerr"}, got_e.size(), v.ne);
    if (v.ne > 0 && got_e.size() > 0)
      chk({v.nm, " code"}, 32'(got_e[0]), 32'(v.e0));
  endtask

  initial begin
    logic bad_stable;
    int   n;

    addv("add", 12,
      128'hA1000C00_01000000_02000000_00000000,
      2, 32'h1, 32'h2, 32'h0, 8'hA1, 3'b010, 0, 2'd0);
    addv("badop", 8,
      128'h55000800_DEADBEEF_00000000_00000000,
      0, 0, 0, 0, 8'h00, 3'b000, 1, 2'd1);
    addv("echo", 8,
      128'hEC000800_11223344_00000000_00000000,
      1, 32'h44332211, 0, 0, 8'hEC, 3'b001, 0, 2'd0);
    addv("badlen", 6,
      128'hA1000600_AABB0000_00000000_00000000,
      0, 0, 0, 0, 8'h00, 3'b000, 1, 2'd2);
    addv("mul", 8,
      128'hB2000800_05060708_00000000_00000000,
      1, 32'h08070605, 0, 0, 8'hB2, 3'b001, 0, 2'd0);
    addv("len4", 4,
      128'hA1000400_00000000_00000000_00000000,
      0, 0, 0, 0, 8'h00, 3'b000, 1, 2'd2);
    addv("div", 16,
      128'hC3001000_01020304_05060708_090A0B0C,
      3, 32'h04030201, 32'h08070605, 32'h0C0B0A09,
      8'hC3, 3'b100, 0, 2'd0);
    addv("len0", 4,
      128'hA1000000_00000000_00000000_00000000,
      0, 0, 0, 0, 8'h00, 3'b000, 1, 2'd2);
    addv("opfirst", 5,
      128'h12000500_77000000_00000000_00000000,
      0, 0, 0, 0, 8'h00, 3'b000, 1, 2'd1);
    addv("len10", 10,
      128'hA1000A00_01020304_05060000_00000000,
      0, 0, 0, 0, 8'h00, 3'b000, 1, 2'd2);
    addv("echo2", 8,
      128'hEC000800_99887766_00000000_00000000,
      1, 32'h66778899, 0, 0, 8'hEC, 3'b001, 0, 2'd0);

    rst      = 1'b1;
    s_tdata  = 8'h00;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst tvalid", 32'(m_tvalid), 0);
    chk("rst tdata", m_tdata, 0);
    chk("rst tuser", 32'(m_tuser), 0);
    chk("rst tlast", 32'(m_tlast), 0);
    chk("rst err", 32'(err_o), 0);
    chk("rst code", 32'(err_code), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("idle s_tready", 32'(s_tready), 1);

    foreach (vecs[i])
      run_vec(vecs[i]);

    // Backpressure: first word held, 12th byte stalls.
    clr_q();
    m_tready   = 1'b0;
    nsent      = 0;
    bad_stable = 1'b0;
    fork
      send_bs(vecs[0].bs, vecs[0].nb);
      begin
        repeat (50) begin
          @(negedge clk);
          if (m_tvalid && m_tdata !== 32'h1)
            bad_stable = 1'b1;
        end
        chk("bp stable", 32'(bad_stable), 0);
        chk("bp tvalid", 32'(m_tvalid), 1);
        chk("bp hold data", m_tdata, 32'h1);
        chk("bp s_tready", 32'(s_tready), 0);
        chk("bp nsent", nsent, 11);
        @(posedge clk);
        #2;
        m_tready = 1'b1;
      end
    join
    settle();
    chk("bp nwords", got_w.size(), 2);
    if (got_w.size() == 2) begin
      chk("bp w0", got_w[0], 32'h1);
      chk("bp w1", got_w[1], 32'h2);
      chk("bp l1", 32'(got_l[1]), 1);
    end
    chk("bp nerr", got_e.size(), 0);

    // Timeout after a partial payload word.
    clr_q();
    send_bs(128'hA1000C00_01020000_00000000_00000000, 6);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (err_o) break;
    end
    chk("tmo cycles", n, 64);
    chk("tmo code", 32'(err_code), 3);
    @(posedge clk);
    #1;
    chk("tmo pulse width", 32'(err_o), 0);
    chk("tmo nwords", got_w.size(), 0);
    run_vec(vecs[2]);

    // Reset mid-packet drops the pending word.
    m_tready = 1'b0;
    send_bs(128'hA1000C00_01000000_00000000_00000000, 8);
    @(posedge clk);
    #1;
    chk("mid tvalid", 32'(m_tvalid), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid rst tvalid", 32'(m_tvalid), 0);
    chk("mid rst tdata", m_tdata, 0);
    m_tready = 1'b1;
    run_vec(vecs[4]);

    // Max legal length: 252 payload bytes.
    clr_q();
    send_one(8'hEC); send_one(8'h00);
    send_one(8'h00); send_one(8'h01);
    for (int j = 0; j < 252; j++)
      send_one(8'(j));
    s_tvalid = 1'b0;
    settle();
    chk("max nwords", got_w.size(), 63);
    if (got_w.size() == 63) begin
      chk("max w0", got_w[0], 32'h03020100);
      chk("max wlast", got_w[62], 32'hFBFAF9F8);
      chk("max l0", 32'(got_l[0]), 0);
      chk("max l62", 32'(got_l[62]), 1);
    end
    chk("max nerr", got_e.size(), 0);

    // One word over the limit: drained as bad length.
    clr_q();
    send_one(8'hA1); send_one(8'h00);
    send_one(8'h04); send_one(8'h01);
    for (int j = 0; j < 256; j++)
      send_one(8'(j));
    s_tvalid = 1'b0;
    settle();
    chk("over nwords", got_w.size(), 0);
    chk("over nerr", got_e.size(), 1);
    if (got_e.size() > 0)
      chk("over code", 32'(got_e[0]), 2);
    run_vec(vecs[6]);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
